decode_issue_stage: RTL and testbench

Decode-to-execute issue stage of the RV32 pipeline. Holds one decoded instruction in a decode latch and presents its register fields to the register file and the RAW hazard/forwarding unit one cycle ahead. It then selects each operand from forwarded or register-file data and launches the instruction into the E-stage register under a valid/ready handshake. It honours `stall_D`, inserts bubbles, and supports a branch/exception `flush`.

---
 rtl/decode_issue_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decode-to-execute issue stage of the RV32 pipeline.
// Holds one decoded instruction in decode latch A and presents its register
// fields (lookahead) one cycle ahead to the register file and hazard unit.
// Operands are picked from forwarded or register-file data, and the
// instruction is launched into the E register under a valid/ready handshake.
// Optional feature: define ISSUE_SKID_EN to add a one-entry skid register
// behind the E output, which removes the combinational ready_E -> ready_out
// path. Without the macro the E register is loaded directly from latch A.

module decode_issue_stage #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       imm_in,
    input  logic [4:0]        rs1_in,
    input  logic [4:0]        rs2_in,
    input  logic [4:0]        rd_in,
    input  logic [4:0]        type_in,
    input  logic              load_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [4:0]        rs1_D,
    output logic [4:0]        rs2_D,
    output logic [4:0]        type_D,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic              stall_D,
    input  logic [31:0]       forward_rs1,
    input  logic [31:0]       forward_rs2,
    input  logic              valid_forward_rs1,
    input  logic              valid_forward_rs2,
    input  logic              flush,
    output logic              valid_E,
    input  logic              ready_E,
    output logic [31:0]       pc_E,
    output logic [31:0]       imm_E,
    output logic [31:0]       op1_E,
    output logic [31:0]       op2_E,
    output logic [4:0]        rd_E,
    output logic [4:0]        type_E,
    output logic              load_E,
    output logic [CTRL_W-1:0] ctrl_E
);

    // Decode latch A
    logic              a_valid;
    logic              a_stall_q;
    logic [31:0]       a_pc;
    logic [31:0]       a_imm;
    logic [4:0]        a_rs1;
    logic [4:0]        a_rs2;
    logic [4:0]        a_rd;
    logic [4:0]        a_type;
    logic              a_load;
    logic [CTRL_W-1:0] a_ctrl;

    logic              acc;
    logic              issue;
    logic              e_can_load;
    logic [31:0]       op1_sel;
    logic [31:0]       op2_sel;

`ifdef ISSUE_SKID_EN
    // Skid entry behind E, filled when an issue meets a stalled E
    logic              skid_valid;
    logic [31:0]       skid_pc;
    logic [31:0]       skid_imm;
    logic [31:0]       skid_op1;
    logic [31:0]       skid_op2;
    logic [4:0]        skid_rd;
    logic [4:0]        skid_type;
    logic              skid_load;
    logic [CTRL_W-1:0] skid_ctrl;

    // E can take an issue whenever the skid entry is free (registered signal)
    assign e_can_load = ~skid_valid;
`else
    // E can take an issue when it is empty or draining this cycle
    assign e_can_load = ~valid_E | ready_E;
`endif

    // Handshake terms; ready is held low while reset is asserted
    assign issue     = a_valid & ~a_stall_q & ~flush & e_can_load;
    assign ready_out = rst & ~flush & (~a_valid | issue);
    assign acc       = valid_in & ready_out;

    // Lookahead fields: the incoming instruction wins, then latch A, else 0
    always_comb begin
        rs1_D  = 5'd0;
        rs2_D  = 5'd0;
        type_D = 5'd0;
        if (acc) begin
            rs1_D  = rs1_in;
            rs2_D  = rs2_in;
            type_D = type_in;
        end else if (a_valid) begin
            rs1_D  = a_rs1;
            rs2_D  = a_rs2;
            type_D = a_type;
        end
    end

    // Operand select: forward beats regfile, x0 reads 0, no-rs2 types get 0
    always_comb begin
        op1_sel = 32'h0;
        op2_sel = 32'h0;
        if (valid_forward_rs1) begin
            op1_sel = forward_rs1;
        end else if (a_rs1 != 5'd0) begin
            op1_sel = rf_rdata1;
        end
        if (a_type[2:0] == 3'b000) begin
            if (valid_forward_rs2) begin
                op2_sel = forward_rs2;
            end else if (a_rs2 != 5'd0) begin
                op2_sel = rf_rdata2;
            end
        end
    end

    // Latch A: load on accept, empty on issue, registered stall verdict
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_valid   <= 1'b0;
            a_stall_q <= 1'b0;
            a_pc      <= 32'h0;
            a_imm     <= 32'h0;
            a_rs1     <= 5'd0;
            a_rs2     <= 5'd0;
            a_rd      <= 5'd0;
            a_type    <= 5'd0;
            a_load    <= 1'b0;
            a_ctrl    <= '0;
        end else if (flush) begin
            a_valid   <= 1'b0;
            a_stall_q <= 1'b0;
        end else begin
            a_stall_q <= stall_D & (acc | a_valid);
            if (acc) begin
                a_valid <= 1'b1;
                a_pc    <= pc_in;
                a_imm   <= imm_in;
                a_rs1   <= rs1_in;
                a_rs2   <= rs2_in;
                a_rd    <= rd_in;
                a_type  <= type_in;
                a_load  <= load_in;
                a_ctrl  <= ctrl_in;
            end else if (issue) begin
                a_valid <= 1'b0;
            end
        end
    end

`ifdef ISSUE_SKID_EN
    // E register plus skid entry: skid captures issues while E is held,
    // and refills E ahead of any newer instruction to keep ordering
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_E    <= 1'b0;
            pc_E       <= 32'h0;
            imm_E      <= 32'h0;
            op1_E      <= 32'h0;
            op2_E      <= 32'h0;
            rd_E       <= 5'd0;
            type_E     <= 5'd0;
            load_E     <= 1'b0;
            ctrl_E     <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'h0;
            skid_imm   <= 32'h0;
            skid_op1   <= 32'h0;
            skid_op2   <= 32'h0;
            skid_rd    <= 5'd0;
            skid_type  <= 5'd0;
            skid_load  <= 1'b0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            valid_E    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (valid_E & ~ready_E) begin
            if (issue) begin
                skid_valid <= 1'b1;
                skid_pc    <= a_pc;
                skid_imm   <= a_imm;
                skid_op1   <= op1_sel;
                skid_op2   <= op2_sel;
                skid_rd    <= a_rd;
                skid_type  <= a_type;
                skid_load  <= a_load;
                skid_ctrl  <= a_ctrl;
            end
        end else if (skid_valid) begin
            valid_E    <= 1'b1;
            pc_E       <= skid_pc;
            imm_E      <= skid_imm;
            op1_E      <= skid_op1;
            op2_E      <= skid_op2;
            rd_E       <= skid_rd;
            type_E     <= skid_type;
            load_E     <= skid_load;
            ctrl_E     <= skid_ctrl;
            skid_valid <= 1'b0;
        end else if (issue) begin
            valid_E <= 1'b1;
            pc_E    <= a_pc;
            imm_E   <= a_imm;
            op1_E   <= op1_sel;
            op2_E   <= op2_sel;
            rd_E    <= a_rd;
            type_E  <= a_type;
            load_E  <= a_load;
            ctrl_E  <= a_ctrl;
        end else if (valid_E & ready_E) begin
            valid_E <= 1'b0;
        end
    end
`else
    // E register: capture on issue, empty after a handshake with no refill
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_E <= 1'b0;
            pc_E    <= 32'h0;
            imm_E   <= 32'h0;
            op1_E   <= 32'h0;
            op2_E   <= 32'h0;
            rd_E    <= 5'd0;
            type_E  <= 5'd0;
            load_E  <= 1'b0;
            ctrl_E  <= '0;
        end else if (flush) begin
            valid_E <= 1'b0;
        end else if (issue) begin
            valid_E <= 1'b1;
            pc_E    <= a_pc;
            imm_E   <= a_imm;
            op1_E   <= op1_sel;
            op2_E   <= op2_sel;
            rd_E    <= a_rd;
            type_E  <= a_type;
            load_E  <= a_load;
            ctrl_E  <= a_ctrl;
        end else if (valid_E & ready_E) begin
            valid_E <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: self-checking bench for decode_issue_stage (default
// build, ISSUE_SKID_EN undefined). A register file / forwarding responder
// answers the lookahead fields one cycle later, a behavioural model predicts
// every output each cycle, and a queue of accepted PCs checks E ordering.

module tb_decode_issue_stage;

    localparam int CTRL_W = 16;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [4:0]        typ;
        logic              load;
        logic [CTRL_W-1:0] ctrl;
    } instr_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       op1;
        logic [31:0]       op2;
        logic [4:0]        rd;
        logic [4:0]        typ;
        logic              load;
        logic [CTRL_W-1:0] ctrl;
    } eout_t;

    logic clk = 1'b0;
    logic rst;
    logic valid_in;
    logic ready_out;
    instr_t curIn;
    logic [4:0] rs1_D, rs2_D, type_D;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic stall_D;
    logic [31:0] forward_rs1, forward_rs2;
    logic valid_forward_rs1, valid_forward_rs2;
    logic flush;
    logic valid_E;
    logic ready_E;
    logic [31:0] pc_E, imm_E, op1_E, op2_E;
    logic [4:0] rd_E, type_E;
    logic load_E;
    logic [CTRL_W-1:0] ctrl_E;

    // Architectural register contents and forwarding table seen by the stage
    logic [31:0] regs [32];
    logic [31:0] fval [32];
    logic [31:0] fmask;

    int nChecks = 0;
    int nFail = 0;

    // Behavioural model state
    logic        modelOn = 1'b0;
    logic        mHv = 1'b0;
    logic        mHstall = 1'b0;
    instr_t      mHeld = '0;
    logic        mEv = 1'b0;
    eout_t       mE = '0;
    logic [31:0] sbq [$];

    always #5 clk = ~clk;

    decode_issue_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_out(ready_out),
        .pc_in(curIn.pc), .imm_in(curIn.imm),
        .rs1_in(curIn.rs1), .rs2_in(curIn.rs2), .rd_in(curIn.rd),
        .type_in(curIn.typ), .load_in(curIn.load), .ctrl_in(curIn.ctrl),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .type_D(type_D),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .stall_D(stall_D),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .valid_forward_rs1(valid_forward_rs1), .valid_forward_rs2(valid_forward_rs2),
        .flush(flush),
        .valid_E(valid_E), .ready_E(ready_E),
        .pc_E(pc_E), .imm_E(imm_E), .op1_E(op1_E), .op2_E(op2_E),
        .rd_E(rd_E), .type_E(type_E), .load_E(load_E), .ctrl_E(ctrl_E)
    );

    // Synchronous register file and registered forward data for the lookahead
    always @(posedge clk) begin
        rf_rdata1         <= regs[rs1_D];
        rf_rdata2         <= regs[rs2_D];
        valid_forward_rs1 <= fmask[rs1_D];
        valid_forward_rs2 <= fmask[rs2_D];
        forward_rs1       <= fval[rs1_D];
        forward_rs2       <= fval[rs2_D];
    end

    // Value an instruction must see for a source register
    function automatic logic [31:0] regSem(input logic [4:0] r);
        if (fmask[r]) return fval[r];
        if (r == 5'd0) return 32'h0;
        return regs[r];
    endfunction

    // What E must show once an instruction has been issued
    function automatic eout_t execView(input instr_t i);
        eout_t e;
        e.pc   = i.pc;
        e.imm  = i.imm;
        e.op1  = regSem(i.rs1);
        e.op2  = (i.typ[2:0] != 3'b000) ? 32'h0 : regSem(i.rs2);
        e.rd   = i.rd;
        e.typ  = i.typ;
        e.load = i.load;
        e.ctrl = i.ctrl;
        return e;
    endfunction

    function automatic instr_t mkInstr(input logic [31:0] pc, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [4:0] typ);
        instr_t i;
        i.pc   = pc;
        i.imm  = pc ^ 32'h5A5A_0000;
        i.rs1  = rs1;
        i.rs2  = rs2;
        i.rd   = rs1 + 5'd3;
        i.typ  = typ;
        i.load = pc[2];
        i.ctrl = pc[15:0] ^ 16'h1234;
        return i;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input instr_t i,
                                 input logic st, input logic re, input logic fl);
        @(posedge clk);
        #1;
        rst      = r;
        valid_in = v;
        curIn    = i;
        stall_D  = st;
        ready_E  = re;
        flush    = fl;
    endtask

    // Compare process: check DUT against the model, then advance the model
    always @(negedge clk) begin : cmp
        logic        mIss, mReady, mAcc;
        logic [4:0]  eRs1, eRs2, eTyp;
        logic [31:0] expPc;
        if (modelOn) begin
            mIss   = mHv & ~mHstall & ~flush & (~mEv | ready_E);
            mReady = rst & ~flush & (~mHv | mIss);
            mAcc   = valid_in & mReady;
            eRs1 = mAcc ? curIn.rs1 : (mHv ? mHeld.rs1 : 5'd0);
            eRs2 = mAcc ? curIn.rs2 : (mHv ? mHeld.rs2 : 5'd0);
            eTyp = mAcc ? curIn.typ : (mHv ? mHeld.typ : 5'd0);

            checkOutput("ready_out", {31'h0, ready_out}, {31'h0, mReady});
            checkOutput("rs1_D", {27'h0, rs1_D}, {27'h0, eRs1});
            checkOutput("rs2_D", {27'h0, rs2_D}, {27'h0, eRs2});
            checkOutput("type_D", {27'h0, type_D}, {27'h0, eTyp});
            checkOutput("valid_E", {31'h0, valid_E}, {31'h0, mEv});
            checkOutput("pc_E", pc_E, mE.pc);
            checkOutput("imm_E", imm_E, mE.imm);
            checkOutput("op1_E", op1_E, mE.op1);
            checkOutput("op2_E", op2_E, mE.op2);
            checkOutput("rd_E", {27'h0, rd_E}, {27'h0, mE.rd});
            checkOutput("type_E", {27'h0, type_E}, {27'h0, mE.typ});
            checkOutput("load_E", {31'h0, load_E}, {31'h0, mE.load});
            checkOutput("ctrl_E", {16'h0, ctrl_E}, {16'h0, mE.ctrl});

            if (rst && !flush && valid_E === 1'b1 && ready_E) begin
                if (sbq.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("[TB] FAIL order: E handed over pc %h, expected no instruction at %0t", pc_E, $time);
                end else begin
                    expPc = sbq.pop_front();
                    checkOutput("order_pc", pc_E, expPc);
                end
            end

            if (!rst) begin
                mHv = 1'b0; mHstall = 1'b0; mHeld = '0;
                mEv = 1'b0; mE = '0;
                sbq.delete();
            end else if (flush) begin
                mHv = 1'b0; mHstall = 1'b0; mEv = 1'b0;
                sbq.delete();
            end else begin
                mHstall = stall_D & (mAcc | mHv);
                if (mIss) begin
                    mE  = execView(mHeld);
                    mEv = 1'b1;
                end else if (mEv && ready_E) begin
                    mEv = 1'b0;
                end
                if (mAcc) begin
                    mHeld = curIn;
                    mHv   = 1'b1;
                    sbq.push_back(curIn.pc);
                end else if (mIss) begin
                    mHv = 1'b0;
                end
            end
        end
    end

    initial begin
        instr_t idle;
        int idx;
        idle = '0;
        rst = 1'b0; valid_in = 1'b1; curIn = mkInstr(32'hF00, 5'd1, 5'd2, 5'd0);
        stall_D = 1'b0; ready_E = 1'b1; flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            fval[i] = $urandom;
        end
        regs[0] = 32'h55;
        fmask = 32'h0;

        // Reset held with valid_in high: nothing accepted, outputs zero
        @(posedge clk);
        modelOn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_ready", {31'h0, ready_out}, 32'h0);
            checkOutput("rst_valid_E", {31'h0, valid_E}, 32'h0);
            checkOutput("rst_pc_E", pc_E, 32'h0);
            checkOutput("rst_op1_E", op1_E, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, idle, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rel_ready", {31'h0, ready_out}, 32'h1);
        checkOutput("rel_valid_E", {31'h0, valid_E}, 32'h0);

        // Back-to-back stream, op1 from the register file
        for (int j = 1; j <= 4; j++) regs[j] = 32'h1000_0000 + j;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, c < 4, mkInstr(32'(4 * c), 5'(c + 1), 5'(c + 2), 5'd0), 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checkOutput("stream_valid", {31'h0, valid_E}, 32'h1);
                checkOutput("stream_pc", pc_E, 32'(4 * (c - 2)));
                checkOutput("stream_op1", op1_E, 32'h1000_0000 + 32'(c - 1));
            end
        end
        checkOutput("stream_drain", {31'h0, valid_E}, 32'h0);

        // Forward override and x0
        regs[5] = 32'h11; fmask = 32'h20; fval[5] = 32'hDEADBEEF;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, c < 2,
                          (c == 0) ? mkInstr(32'h40, 5'd5, 5'd0, 5'd1) : mkInstr(32'h44, 5'd0, 5'd0, 5'd0),
                          1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (c == 2) checkOutput("fwd_op1", op1_E, 32'hDEADBEEF);
            if (c == 3) begin
                checkOutput("x0_op1", op1_E, 32'h0);
                checkOutput("x0_op2", op2_E, 32'h0);
            end
        end

        // Load-use stall on instruction 2, which then takes a forward
        fmask = 32'h80; fval[7] = 32'hCAFE0007;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, c < 5,
                          (c == 0) ? mkInstr(32'h100, 5'd1, 5'd2, 5'd0) :
                          (c == 1) ? mkInstr(32'h104, 5'd7, 5'd0, 5'd2) :
                                     mkInstr(32'h108, 5'd2, 5'd3, 5'd0),
                          (c == 1 || c == 2), 1'b1, 1'b0);
            @(negedge clk);
            case (c)
                2: begin
                    checkOutput("stall_pc1", pc_E, 32'h100);
                    checkOutput("stall_ready_c2", {31'h0, ready_out}, 32'h0);
                end
                3: begin
                    checkOutput("stall_ready_c3", {31'h0, ready_out}, 32'h0);
                    checkOutput("stall_bubble1", {31'h0, valid_E}, 32'h0);
                end
                4: checkOutput("stall_bubble2", {31'h0, valid_E}, 32'h0);
                5: begin
                    checkOutput("stall_pc2", pc_E, 32'h104);
                    checkOutput("stall_fwd_op1", op1_E, 32'hCAFE0007);
                end
                6: checkOutput("stall_pc3", pc_E, 32'h108);
                default: ;
            endcase
        end

        // Backpressure for three cycles mid-stream
        fmask = 32'h0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, idx < 4, mkInstr(32'h200 + 32'(4 * idx), 5'(idx + 1), 5'd0, 5'd0),
                          1'b0, !(c >= 3 && c <= 5), 1'b0);
            @(negedge clk);
            if (c == 2) checkOutput("bp_pc0", pc_E, 32'h200);
            if (c >= 3 && c <= 6) checkOutput("bp_hold_pc", pc_E, 32'h204);
            if (c >= 3 && c <= 5) begin
                checkOutput("bp_hold_valid", {31'h0, valid_E}, 32'h1);
                checkOutput("bp_ready", {31'h0, ready_out}, 32'h0);
            end
            if (c == 7) checkOutput("bp_pc2", pc_E, 32'h208);
            if (c == 8) checkOutput("bp_pc3", pc_E, 32'h20C);
            if (c == 9) checkOutput("bp_drain", {31'h0, valid_E}, 32'h0);
            if (valid_in && ready_out) idx++;
        end

        // Flush with A and E both valid and a new input presented
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, c < 3, mkInstr(32'h300 + 32'(4 * c), 5'd3, 5'd4, 5'd0),
                          1'b0, 1'b1, c == 2);
            @(negedge clk);
            if (c == 2) begin
                checkOutput("fl_valid_before", {31'h0, valid_E}, 32'h1);
                checkOutput("fl_ready", {31'h0, ready_out}, 32'h0);
            end
            if (c == 3) begin
                checkOutput("fl_killed", {31'h0, valid_E}, 32'h0);
                checkOutput("fl_a_empty", {31'h0, ready_out}, 32'h1);
            end
            if (c == 4) checkOutput("fl_not_issued", {31'h0, valid_E}, 32'h0);
        end

        // Randomized traffic with stalls, backpressure, flushes and resets
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            fval[i] = $urandom;
        end
        fmask = $urandom;
        for (int c = 0; c < 2500; c++) begin
            instr_t r;
            r.pc   = $urandom;
            r.imm  = $urandom;
            r.rs1  = 5'($urandom_range(0, 31));
            r.rs2  = 5'($urandom_range(0, 31));
            r.rd   = 5'($urandom_range(0, 31));
            r.typ  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            r.load = 1'($urandom_range(0, 1));
            r.ctrl = 16'($urandom);
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7, r,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 39) == 0);
        end
        applyStimulus(1'b1, 1'b0, idle, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, idle, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
